ex_result_forward: RTL and testbench
====================================

// Module: ex_result_forward
// PURPOSE
//  Return path for the EX-stage operand muxes: carries ALU/load results from EX through MEM to WB.
//  Drives the register-file write port.
//  Supplies forwarded rs/rt operands and selects back to ID/EX, and raises the load-use stall.
//  Sits between the ALU output, data memory read port, register file and ID/EX operand muxes.
// PARAMETERS
//  DATA_W  32  operand/result width
//  REG_AW  6   register address width (64 registers; r0 is an ordinary, writable register)
// PORTS
//  clk           in   1       rising-edge clock
//  rst_n         in   1       asynchronous active-low reset
//  ex_valid      in   1       EX holds a real instruction this cycle
//  ex_wr_en      in   1       EX instruction writes rd
//  ex_is_load    in   1       EX instruction is a load (result comes from memory)
//  ex_rd         in   REG_AW  EX destination register
//  ex_result     in   DATA_W  ALU result (load: effective address, not written)
//  mem_rdata     in   DATA_W  data memory read data, valid during the cycle the load occupies M
//  id_rs, id_rt  in   REG_AW  source registers of the instruction in ID
//  rf_we         out  1       register-file write enable (W stage)
//  rf_waddr      out  REG_AW  register-file write address
//  rf_wdata      out  DATA_W  register-file write data
//  fwd_rs_sel    out  2       0=regfile, 1=M-stage ALU result, 2=W-stage data
//  fwd_rt_sel    out  2       same encoding for rt
//  fwd_rs_data   out  DATA_W  forwarded rs value (0 when sel=0)
//  fwd_rt_data   out  DATA_W  forwarded rt value (0 when sel=0)
//  stall         out  1       hold PC and IF/ID; upstream injects a bubble into EX
// BEHAVIOUR
//  - Two registered stages: M (captured from EX) and W (captured from M). Each holds {valid,wr,load,rd,data}.
//  - Posedge: M <= EX fields, with valid = ex_valid & ~stall.
//  - Posedge: W <= M fields; W.data = M.load ? mem_rdata : M.data.
//  - rf_we = W.valid & W.wr; rf_waddr = W.rd; rf_wdata = W.data. All are registered; latency EX->regfile = 2 clocks.
//  - Forward match: stage.valid & stage.wr & stage.rd == id_rX.
//  - Priority: M (non-load) over W; a younger M result always wins.
//  - An M-stage load never forwards. A match on it asserts stall (combinational) for exactly one cycle.
//    The next cycle the load is in W, so it forwards with sel=2.
//  - A W-stage match that coincides with rf write is still forwarded (sel=2); no regfile write-through is assumed.
//  - stall is combinational from id_rs/id_rt and M. It must not depend on ex_* inputs (no comb loop).
//  - ex_valid=0 or ex_wr_en=0 entries flow through but never match or write.
//  - Reset (async, rst_n low): M.valid=W.valid=0, all stage data/addr=0.
//    Outputs then read rf_we=0, rf_waddr=0, rf_wdata=0, sel=0, fwd data=0, stall=0.
//  - Deasserting reset mid-flight: no partially written result is kept; in-flight instructions are lost by design.
// CONFIGURATION
//  RES_FWD_EN defined: forwarding as above; stall only on load-use.
//  RES_FWD_EN undefined:
//   - fwd_*_sel and fwd_*_data are tied to 0.
//   - stall = any match against M or W (load or not); the pipe drains before ID proceeds.
//   - Maximum stall is 2 cycles.
// STRUCTURE
//  Shared package: DATA_W/REG_AW defaults and FWD_RF=2'd0 / FWD_MEM=2'd1 / FWD_WB=2'd2.
//  Package also holds typedef result_stage_t {valid,wr,load,rd,data}.
//  One sub-module: fwd_match (instantiated twice, rs and rt): stage compares -> {sel,data,hazard}.
// TESTING
//  1 Reset: hold rst_n=0 mid-stream with valid EX -> all outputs 0, no rf_we after release until 2 clk of new EX.
//  2 Write timing: ADD r5=0x0000_00AA in EX at cycle t -> rf_we=1, waddr=5, wdata=0xAA at t+2 only.
//  3 Back-to-back: r3=0x11 then r3=0x22 in EX; next ID reads r3.
//    Expected: sel=1, data=0x22; the following cycle sel=2, data=0x22.
//  4 Load-use: LD r7 (mem_rdata=0xDEADBEEF) then ID rs=r7 -> stall=1 one cycle.
//    Then sel=2, data=0xDEADBEEF, and the EX bubble is not written.
//  5 rs=rt=r9 both matching W with 0x5 -> both sels=2, both data=0x5; ex_wr_en=0 on r9 -> no match, sel=0.
//  6 RES_FWD_EN undefined: ADD r4 then ID uses r4 -> stall 2 cycles, sels stay 0, release when W retires.

Source files
------------

// File: rtl/ex_result_forward_pkg.sv
// Shared types and constants for the EX->M->W result return path and its forwarding network.
// Forwarding behaviour is selected by the RES_FWD_EN macro (see ex_result_forward.sv).
package ex_result_forward_pkg;

  localparam int DATA_W_DFLT = 32;
  localparam int REG_AW_DFLT = 6;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  typedef struct packed {
    logic                   valid;
    logic                   wr;
    logic                   load;
    logic [REG_AW_DFLT-1:0] rd;
    logic [DATA_W_DFLT-1:0] data;
  } result_stage_t;

  // A stage can only satisfy a source operand if it holds a real, writing instruction.
  function automatic logic stage_hit(input result_stage_t s, input logic [REG_AW_DFLT-1:0] r);
    return s.valid & s.wr & (s.rd == r);
  endfunction

endpackage

// File: rtl/ex_result_forward_fwd_match.sv
// Per-operand compare of one ID source register against the M and W result stages.
// RES_FWD_EN defined: forward (M non-load over W), hazard on M-stage load; undefined: hazard on any match.
module ex_result_forward_fwd_match
  import ex_result_forward_pkg::*;
#(
  parameter int DATA_W = DATA_W_DFLT,
  parameter int REG_AW = REG_AW_DFLT
) (
  input  logic [REG_AW-1:0] i_id_r,
  input  result_stage_t     i_m,
  input  result_stage_t     i_w,
  output logic [1:0]        o_sel,
  output logic [DATA_W-1:0] o_data,
  output logic              o_hazard
);

  logic w_m_hit;
  logic w_w_hit;
  logic w_unused;

  assign w_m_hit = stage_hit(i_m, i_id_r);
  assign w_w_hit = stage_hit(i_w, i_id_r);

`ifdef RES_FWD_EN
  assign w_unused = i_w.load;

  always_comb begin
    o_sel    = FWD_RF;
    o_data   = '0;
    o_hazard = 1'b0;
    // Load data is not available until the load reaches W, so an M-stage load match stalls.
    if (w_m_hit && i_m.load) begin
      o_hazard = 1'b1;
    end else if (w_m_hit) begin
      o_sel  = FWD_MEM;
      o_data = i_m.data;
    end else if (w_w_hit) begin
      o_sel  = FWD_WB;
      o_data = i_w.data;
    end
  end
`else
  assign w_unused = ^{i_m.load, i_m.data, i_w.load, i_w.data};

  always_comb begin
    o_sel    = FWD_RF;
    o_data   = '0;
    o_hazard = w_m_hit | w_w_hit;
  end
`endif

endmodule

// File: rtl/ex_result_forward.sv
// EX->M->W result pipeline: drives the register-file write port, forwarded operands and load-use stall.
// Define RES_FWD_EN to enable operand forwarding; otherwise any M/W dependency stalls until writeback.
module ex_result_forward
  import ex_result_forward_pkg::*;
#(
  parameter int DATA_W = DATA_W_DFLT,
  parameter int REG_AW = REG_AW_DFLT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic              ex_wr_en,
  input  logic              ex_is_load,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [DATA_W-1:0] ex_result,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [1:0]        fwd_rs_sel,
  output logic [1:0]        fwd_rt_sel,
  output logic [DATA_W-1:0] fwd_rs_data,
  output logic [DATA_W-1:0] fwd_rt_data,
  output logic              stall
);

  result_stage_t r_m;
  result_stage_t r_w;
  logic          w_haz_rs;
  logic          w_haz_rt;
  logic          w_stall;

  // M stage: capture EX; a stalled cycle turns the EX slot into a bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m <= '0;
    end else begin
      r_m.valid <= ex_valid & ~w_stall;
      r_m.wr    <= ex_wr_en;
      r_m.load  <= ex_is_load;
      r_m.rd    <= ex_rd;
      r_m.data  <= ex_result;
    end
  end

  // W stage: loads pick up memory read data here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_w <= '0;
    end else begin
      r_w.valid <= r_m.valid;
      r_w.wr    <= r_m.wr;
      r_w.load  <= r_m.load;
      r_w.rd    <= r_m.rd;
      r_w.data  <= r_m.load ? mem_rdata : r_m.data;
    end
  end

  assign rf_we    = r_w.valid & r_w.wr;
  assign rf_waddr = r_w.rd;
  assign rf_wdata = r_w.data;

  ex_result_forward_fwd_match #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_fwd_rs (
    .i_id_r   (id_rs),
    .i_m      (r_m),
    .i_w      (r_w),
    .o_sel    (fwd_rs_sel),
    .o_data   (fwd_rs_data),
    .o_hazard (w_haz_rs)
  );

  ex_result_forward_fwd_match #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_fwd_rt (
    .i_id_r   (id_rt),
    .i_m      (r_m),
    .i_w      (r_w),
    .o_sel    (fwd_rt_sel),
    .o_data   (fwd_rt_data),
    .o_hazard (w_haz_rt)
  );

  // Depends only on ID sources and stage registers, never on ex_* inputs.
  assign w_stall = w_haz_rs | w_haz_rt;
  assign stall   = w_stall;

endmodule

// File: tb/tb_ex_result_forward.sv
// Directed bench for ex_result_forward; expectations follow the RES_FWD_EN macro of the build.
module tb_ex_result_forward;
  import ex_result_forward_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_wr_en;
  logic        ex_is_load;
  logic [5:0]  ex_rd;
  logic [31:0] ex_result;
  logic [31:0] mem_rdata;
  logic [5:0]  id_rs;
  logic [5:0]  id_rt;
  logic        rf_we;
  logic [5:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [1:0]  fwd_rs_sel;
  logic [1:0]  fwd_rt_sel;
  logic [31:0] fwd_rs_data;
  logic [31:0] fwd_rt_data;
  logic        stall;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ex_result_forward dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ex_valid    (ex_valid),
    .ex_wr_en    (ex_wr_en),
    .ex_is_load  (ex_is_load),
    .ex_rd       (ex_rd),
    .ex_result   (ex_result),
    .mem_rdata   (mem_rdata),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .fwd_rs_sel  (fwd_rs_sel),
    .fwd_rt_sel  (fwd_rt_sel),
    .fwd_rs_data (fwd_rs_data),
    .fwd_rt_data (fwd_rt_data),
    .stall       (stall)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_ex(input logic v, input logic wr, input logic ld,
                          input logic [5:0] rd, input logic [31:0] res);
    ex_valid   = v;
    ex_wr_en   = wr;
    ex_is_load = ld;
    ex_rd      = rd;
    ex_result  = res;
  endtask

  task automatic ex_idle();
    drive_ex(1'b0, 1'b0, 1'b0, 6'd0, 32'd0);
  endtask

  task automatic set_id(input logic [5:0] rs, input logic [5:0] rt);
    id_rs = rs;
    id_rt = rt;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  initial begin
    rst_n     = 1'b0;
    mem_rdata = 32'd0;
    ex_idle();
    set_id(6'd1, 6'd2);
    settle();
    settle();
    check("rst_rf_we",    32'(rf_we), 0);
    check("rst_rf_waddr", 32'(rf_waddr), 0);
    check("rst_rf_wdata", rf_wdata, 0);
    check("rst_stall",    32'(stall), 0);
    check("rst_sels",     32'({fwd_rs_sel, fwd_rt_sel}), 0);
    check("rst_fwd_data", fwd_rs_data | fwd_rt_data, 0);
    next_cycle();
    rst_n = 1'b1;

    // Write timing: ADD r5 = 0xAA, visible on the write port exactly two clocks later
    drive_ex(1'b1, 1'b1, 1'b0, 6'd5, 32'h0000_00AA);
    settle();
    check("wr_t0_we", 32'(rf_we), 0);
    next_cycle();
    ex_idle();
    settle();
    check("wr_t1_we", 32'(rf_we), 0);
    next_cycle();
    settle();
    check("wr_t2_we",    32'(rf_we), 1);
    check("wr_t2_waddr", 32'(rf_waddr), 5);
    check("wr_t2_wdata", rf_wdata, 32'h0000_00AA);
    next_cycle();
    settle();
    check("wr_t3_we", 32'(rf_we), 0);

    // Reset asserted mid-stream with valid instructions in EX and M
    next_cycle();
    drive_ex(1'b1, 1'b1, 1'b0, 6'd6, 32'h66);
    next_cycle();
    drive_ex(1'b1, 1'b1, 1'b0, 6'd6, 32'h67);
    set_id(6'd6, 6'd6);
    settle();
    #1;
    rst_n = 1'b0;
    #1;
    check("mrst_rf_we",   32'(rf_we), 0);
    check("mrst_stall",   32'(stall), 0);
    check("mrst_sel",     32'({fwd_rs_sel, fwd_rt_sel}), 0);
    check("mrst_fwddata", fwd_rs_data, 0);
    next_cycle();
    settle();
    check("mrst_hold_we",   32'(rf_we), 0);
    check("mrst_hold_addr", 32'(rf_waddr), 0);
    check("mrst_hold_data", rf_wdata, 0);
    next_cycle();
    rst_n = 1'b1;
    ex_idle();
    set_id(6'd1, 6'd2);
    settle();
    check("mrst_rel0_we", 32'(rf_we), 0);
    next_cycle();
    settle();
    check("mrst_rel1_we", 32'(rf_we), 0);
    next_cycle();
    next_cycle();

`ifdef RES_FWD_EN
    // Back-to-back writes to r3: younger M result wins over W, then W forwards
    drive_ex(1'b1, 1'b1, 1'b0, 6'd3, 32'h11);
    next_cycle();
    drive_ex(1'b1, 1'b1, 1'b0, 6'd3, 32'h22);
    next_cycle();
    ex_idle();
    set_id(6'd3, 6'd2);
    settle();
    check("b2b_m_sel",   32'(fwd_rs_sel), 32'(FWD_MEM));
    check("b2b_m_data",  fwd_rs_data, 32'h22);
    check("b2b_m_stall", 32'(stall), 0);
    check("b2b_rt_sel",  32'(fwd_rt_sel), 32'(FWD_RF));
    next_cycle();
    settle();
    check("b2b_w_sel",  32'(fwd_rs_sel), 32'(FWD_WB));
    check("b2b_w_data", fwd_rs_data, 32'h22);
    next_cycle();
    set_id(6'd1, 6'd2);
    next_cycle();

    // Load-use: LD r7 then ID rs=r7; instruction in EX during the stall is squashed
    drive_ex(1'b1, 1'b1, 1'b1, 6'd7, 32'h0000_0100);
    next_cycle();
    drive_ex(1'b1, 1'b1, 1'b0, 6'd8, 32'h99);
    mem_rdata = 32'hDEAD_BEEF;
    set_id(6'd7, 6'd2);
    settle();
    check("ld_stall",   32'(stall), 1);
    check("ld_m_nofwd", 32'(fwd_rs_sel), 32'(FWD_RF));
    next_cycle();
    ex_idle();
    mem_rdata = 32'h0BAD_F00D;
    settle();
    check("ld_w_stall", 32'(stall), 0);
    check("ld_w_sel",   32'(fwd_rs_sel), 32'(FWD_WB));
    check("ld_w_data",  fwd_rs_data, 32'hDEAD_BEEF);
    check("ld_rf_we",   32'(rf_we), 1);
    check("ld_rf_addr", 32'(rf_waddr), 7);
    check("ld_rf_data", rf_wdata, 32'hDEAD_BEEF);
    next_cycle();
    settle();
    check("ld_bubble_we", 32'(rf_we), 0);
    next_cycle();
    set_id(6'd1, 6'd2);
    next_cycle();

    // rs = rt = r9 both match W; then a non-writing r9 never matches
    drive_ex(1'b1, 1'b1, 1'b0, 6'd9, 32'h5);
    next_cycle();
    ex_idle();
    next_cycle();
    set_id(6'd9, 6'd9);
    settle();
    check("r9_rs_sel",  32'(fwd_rs_sel), 32'(FWD_WB));
    check("r9_rt_sel",  32'(fwd_rt_sel), 32'(FWD_WB));
    check("r9_rs_data", fwd_rs_data, 32'h5);
    check("r9_rt_data", fwd_rt_data, 32'h5);
    next_cycle();
    drive_ex(1'b1, 1'b0, 1'b0, 6'd9, 32'h77);
    set_id(6'd1, 6'd2);
    next_cycle();
    ex_idle();
    set_id(6'd9, 6'd9);
    settle();
    check("nowr_m_sel",   32'(fwd_rs_sel), 32'(FWD_RF));
    check("nowr_m_stall", 32'(stall), 0);
    next_cycle();
    settle();
    check("nowr_w_sel", 32'(fwd_rt_sel), 32'(FWD_RF));
    check("nowr_w_we",  32'(rf_we), 0);
`else
    // No forwarding: ADD r4 then ID uses r4 -> two stall cycles, sels stay 0
    drive_ex(1'b1, 1'b1, 1'b0, 6'd4, 32'h44);
    settle();
    check("nf_t0_stall", 32'(stall), 0);
    next_cycle();
    drive_ex(1'b1, 1'b1, 1'b0, 6'd10, 32'hAB);
    set_id(6'd4, 6'd2);
    settle();
    check("nf_m_stall", 32'(stall), 1);
    check("nf_m_sel",   32'({fwd_rs_sel, fwd_rt_sel}), 0);
    check("nf_m_data",  fwd_rs_data, 0);
    next_cycle();
    ex_idle();
    settle();
    check("nf_w_stall", 32'(stall), 1);
    check("nf_w_we",    32'(rf_we), 1);
    check("nf_w_addr",  32'(rf_waddr), 4);
    check("nf_w_data",  rf_wdata, 32'h44);
    next_cycle();
    settle();
    check("nf_rel_stall", 32'(stall), 0);
    check("nf_bubble_we", 32'(rf_we), 0);
    next_cycle();
    set_id(6'd1, 6'd2);
    next_cycle();

    // Load via rt: same two-cycle stall, load data written from W
    drive_ex(1'b1, 1'b1, 1'b1, 6'd7, 32'h100);
    next_cycle();
    ex_idle();
    mem_rdata = 32'hDEAD_BEEF;
    set_id(6'd1, 6'd7);
    settle();
    check("nfl_m_stall", 32'(stall), 1);
    next_cycle();
    mem_rdata = 32'h0BAD_F00D;
    settle();
    check("nfl_w_stall", 32'(stall), 1);
    check("nfl_w_sel",   32'(fwd_rt_sel), 0);
    check("nfl_w_data",  rf_wdata, 32'hDEAD_BEEF);
    next_cycle();
    settle();
    check("nfl_rel_stall", 32'(stall), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
